vin_pwmcounter_scheduler: RTL



---
 rtl/vin_pwmcounter_scheduler.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/vin_pwmcounter_scheduler.sv
`timescale 1ns/1ps
// vin_pwmcounter_scheduler: round-robin period measurement over CHANNELS
// pulse inputs, one shared counter, per-channel result slots + valid mask.
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high reset
//   SIGNAL     [CHANNELS] asynchronous pulse inputs
//   enable     run the scheduler (sampled in IDLE and STORE only)
//   frequency  [CHANNELS*32] per-channel period in clk cycles, slot i at [32*i+:32]
//   valid      [CHANNELS] slot i holds a completed measurement
//   channel    [4] channel currently selected
//   done       one-cycle pulse in the cycle a slot is written
//   busy       high whenever the scheduler is not idle
module vin_pwmcounter_scheduler #(
  parameter int          CHANNELS = 4,
  parameter int unsigned TIMEOUT  = 50000000,
  parameter int          SETTLE   = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [CHANNELS-1:0]      SIGNAL,
  input  logic                     enable,
  output logic [CHANNELS*32-1:0]   frequency,
  output logic [CHANNELS-1:0]      valid,
  output logic [3:0]               channel,
  output logic                     done,
  output logic                     busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_ARM,
    S_MEASURE,
    S_STORE
  } state_t;

  localparam logic [31:0] TMAX    = 32'(TIMEOUT - 1);
  localparam logic [31:0] SMAX    = 32'(SETTLE - 1);
  localparam logic [3:0]  CH_LAST = 4'(CHANNELS - 1);

  state_t              state_q;
  logic [CHANNELS-1:0] s1_q;
  logic [CHANNELS-1:0] s2_q;
  logic [CHANNELS-1:0] prev_q;
  logic [31:0]         scount_q;
  logic [31:0]         tcount_q;
  logic [31:0]         count_q;
  logic [31:0]         result_q;
  logic                ok_q;
  logic [31:0]         freq_q [CHANNELS];
  logic [CHANNELS-1:0] valid_q;
  logic [3:0]          channel_q;
  logic                done_q;
  logic                busy_q;

  logic                rise_d;
  logic [3:0]          chan_d;

  // Synchronizers and prev-flops run on every channel all the time, so
  // the prev-flop of a freshly selected channel is already valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q   <= '0;
      s2_q   <= '0;
      prev_q <= '0;
    end else begin
      s1_q   <= SIGNAL;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  always_comb begin
    rise_d = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (channel_q == 4'(i)) rise_d = s2_q[i] & ~prev_q[i];
    end
  end

  assign chan_d = (channel_q == CH_LAST) ? 4'd0 : channel_q + 4'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      scount_q  <= '0;
      tcount_q  <= '0;
      count_q   <= '0;
      result_q  <= '0;
      ok_q      <= 1'b0;
      valid_q   <= '0;
      channel_q <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) freq_q[i] <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (enable) begin
            state_q  <= S_SETTLE;
            scount_q <= '0;
            busy_q   <= 1'b1;
          end
        end
        S_SETTLE: begin
          if (scount_q == SMAX) begin
            state_q  <= S_ARM;
            tcount_q <= '0;
          end else begin
            scount_q <= scount_q + 32'd1;
          end
        end
        S_ARM: begin
          tcount_q <= tcount_q + 32'd1;
          // A rise in the timeout cycle still starts the measurement.
          if (rise_d) begin
            state_q <= S_MEASURE;
            count_q <= 32'd1;
          end else if (tcount_q == TMAX) begin
            state_q  <= S_STORE;
            result_q <= '0;
            ok_q     <= 1'b0;
            done_q   <= 1'b1;
          end
        end
        S_MEASURE: begin
          tcount_q <= tcount_q + 32'd1;
          count_q  <= count_q + 32'd1;
          if (rise_d) begin
            state_q  <= S_STORE;
            result_q <= count_q;
            ok_q     <= 1'b1;
            done_q   <= 1'b1;
          end else if (tcount_q == TMAX) begin
            state_q  <= S_STORE;
            result_q <= '0;
            ok_q     <= 1'b0;
            done_q   <= 1'b1;
          end
        end
        S_STORE: begin
          for (int i = 0; i < CHANNELS; i++) begin
            if (channel_q == 4'(i)) begin
              freq_q[i]  <= result_q;
              valid_q[i] <= ok_q;
            end
          end
          done_q    <= 1'b0;
          channel_q <= chan_d;
          if (enable) begin
            state_q  <= S_SETTLE;
            scount_q <= '0;
            busy_q   <= 1'b1;
          end else begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_slot
    assign frequency[32*g +: 32] = freq_q[g];
  end

  assign valid   = valid_q;
  assign channel = channel_q;
  assign done    = done_q;
  assign busy    = busy_q;

endmodule
